alu_pwr_seq: RTL and testbench

Power-sequencing front end for the power-gated ALU datapath. Generates `alu_pwr_en` and `iso_en` in the required safe order, counting settle delays, and gates the ALU `start` strobe with a valid/ready handshake so no operation is issued while the ALU is unpowered, isolated or draining. Sits directly upstream of the ALU top: its outputs drive that block's `alu_pwr_en`, `iso_en` and `start` inputs, and it consumes the ALU `busy` flag.

---
 rtl/alu_pwr_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_pwr_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_pwr_seq.sv
// alu_pwr_seq: power-sequencing front end for the power-gated ALU datapath.
// Drives alu_pwr_en and iso_en in a safe order with settle delays, and gates the
// ALU start strobe so nothing is issued unless the ALU is powered and released.
//
// Ports:
//   clk, rst_n               clock (rising edge), synchronous active-low reset
//   wake_req, sleep_req      level power-up / power-down requests
//   start_in                 upstream start valid, held until accepted
//   start_ready, start_out   accept indication and start strobe to the ALU
//   alu_busy                 busy flag from the ALU
//   alu_pwr_en, iso_en       ALU power enable and output isolation (registered)
//   pwr_state                state code: OFF=0 PWR_UP=1 ON=2 DRAIN=3 ISO=4
//   on_pulse, off_pulse      one-cycle pulses on entry to ON / OFF
//
// Optional feature: define ALU_PWR_AUTO_OFF_EN to power down automatically after
// IDLE_TIMEOUT idle cycles in ON.
module alu_pwr_seq #(
  parameter int unsigned PWR_UP_WAIT  = 4,
  parameter int unsigned ISO_SETUP    = 2,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wake_req,
  input  logic       sleep_req,
  input  logic       start_in,
  output logic       start_ready,
  output logic       start_out,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic [2:0] pwr_state,
  output logic       on_pulse,
  output logic       off_pulse
);

  localparam int unsigned MaxSeq = (PWR_UP_WAIT > ISO_SETUP) ? PWR_UP_WAIT : ISO_SETUP;
  localparam int unsigned MaxDly = (MaxSeq > IDLE_TIMEOUT) ? MaxSeq : IDLE_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxDly) + 1;

  localparam logic [CntW-1:0] PwrUpLoad = CntW'(PWR_UP_WAIT - 1);
  localparam logic [CntW-1:0] IsoLoad   = CntW'(ISO_SETUP - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StPwrUp = 3'd1,
    StOn    = 3'd2,
    StDrain = 3'd3,
    StIso   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drain_low_q, drain_low_d;  // busy was low in the previous DRAIN cycle
  logic            pwr_en_q, pwr_en_d;
  logic            iso_q, iso_d;
  logic            on_pulse_q, on_pulse_d;
  logic            off_pulse_q, off_pulse_d;
  logic            sleep_go;

`ifdef ALU_PWR_AUTO_OFF_EN
  localparam logic [CntW-1:0] IdleLast = CntW'(IDLE_TIMEOUT - 1);

  logic [CntW-1:0] idle_q, idle_d;
  logic            idle_hit;

  // Idle count clears on any activity and on leaving ON; it stops at the
  // timeout because the FSM leaves ON in that same cycle.
  always_comb begin
    idle_d   = '0;
    idle_hit = 1'b0;
    if (state_q == StOn && !start_in && !alu_busy) begin
      idle_hit = (idle_q == IdleLast);
      if (!idle_hit) begin
        idle_d = idle_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign sleep_go = sleep_req | idle_hit;
`else
  assign sleep_go = sleep_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_low_d = 1'b0;
    case (state_q)
      StOff: begin
        if (wake_req || start_in) begin
          state_d = StPwrUp;
          cnt_d   = PwrUpLoad;
        end
      end
      StPwrUp: begin
        if (cnt_q == '0) begin
          state_d = StOn;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StOn: begin
        if (sleep_go) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!alu_busy) begin
          if (drain_low_q) begin
            state_d = StIso;
            cnt_d   = IsoLoad;
          end else begin
            drain_low_d = 1'b1;
          end
        end
      end
      StIso: begin
        if (cnt_q == '0) begin
          state_d = StOff;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase

    // Power and isolation follow the next state so they change with the state flop.
    pwr_en_d    = (state_d != StOff);
    iso_d       = (state_d == StOff) || (state_d == StPwrUp) || (state_d == StIso);
    on_pulse_d  = (state_d == StOn) && (state_q != StOn);
    off_pulse_d = (state_d == StOff) && (state_q != StOff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      drain_low_q <= 1'b0;
      pwr_en_q    <= 1'b0;
      iso_q       <= 1'b1;
      on_pulse_q  <= 1'b0;
      off_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_low_q <= drain_low_d;
      pwr_en_q    <= pwr_en_d;
      iso_q       <= iso_d;
      on_pulse_q  <= on_pulse_d;
      off_pulse_q <= off_pulse_d;
    end
  end

  assign start_ready = (state_q == StOn);
  assign start_out   = start_ready & start_in;
  assign alu_pwr_en  = pwr_en_q;
  assign iso_en      = iso_q;
  assign pwr_state   = state_q;
  assign on_pulse    = on_pulse_q;
  assign off_pulse   = off_pulse_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Self-checking bench for alu_pwr_seq. Each cycle the stimulus step pushes the
// expected output vector to a scoreboard; it is popped and compared mid-cycle.
// Vector: {pwr_state[2:0], alu_pwr_en, iso_en, start_ready, start_out, on_pulse, off_pulse}
module tb_alu_pwr_seq;

  logic       clk;
  logic       rst_n;
  logic       wake_req;
  logic       sleep_req;
  logic       start_in;
  logic       start_ready;
  logic       start_out;
  logic       alu_busy;
  logic       alu_pwr_en;
  logic       iso_en;
  logic [2:0] pwr_state;
  logic       on_pulse;
  logic       off_pulse;

  int checks;
  int errors;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  alu_pwr_seq #(
    .PWR_UP_WAIT (4),
    .ISO_SETUP   (2),
    .IDLE_TIMEOUT(8)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wake_req   (wake_req),
    .sleep_req  (sleep_req),
    .start_in   (start_in),
    .start_ready(start_ready),
    .start_out  (start_out),
    .alu_busy   (alu_busy),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .pwr_state  (pwr_state),
    .on_pulse   (on_pulse),
    .off_pulse  (off_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, act, exp);
    end
  endtask

  // Expected vector; power/isolation derived from the state code.
  function automatic logic [8:0] ev(input int st, input bit rdy, input bit so, input bit on,
                                    input bit off);
    logic [2:0] s;
    logic       pwr;
    logic       iso;
    s   = 3'(st);
    pwr = (st >= 1 && st <= 4);
    iso = (st == 0 || st == 1 || st == 4);
    return {s, pwr, iso, rdy, so, on, off};
  endfunction

  // One clock cycle: drive inputs, push expectation, compare mid-cycle.
  task automatic cyc(input string tag, input bit rst, input bit wake, input bit sleep,
                     input bit start, input bit busy, input logic [8:0] e);
    logic [8:0] got;
    rst_n     = rst;
    wake_req  = wake;
    sleep_req = sleep;
    start_in  = start;
    alu_busy  = busy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got = {pwr_state, alu_pwr_en, iso_en, start_ready, start_out, on_pulse, off_pulse};
    check_eq(tag_q.pop_front(), got, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    wake_req  = 1'b0;
    sleep_req = 1'b0;
    start_in  = 1'b0;
    alu_busy  = 1'b0;
    @(posedge clk);
    #1;

    // Reset state and idle OFF
    cyc("reset", 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) cyc("idle_off", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));

    // Wake (with simultaneous sleep: wake wins in OFF)
    cyc("wake_off", 1, 1, 1, 0, 0, ev(0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) cyc("pwr_up", 1, 0, 0, 0, 0, ev(1, 0, 0, 0, 0));
    cyc("on_entry", 1, 0, 0, 0, 0, ev(2, 1, 0, 1, 0));
    cyc("on_hold", 1, 0, 0, 0, 0, ev(2, 1, 0, 0, 0));
    // Sleep with simultaneous wake: sleep wins in ON
    cyc("sleep_on", 1, 1, 1, 0, 0, ev(2, 1, 0, 0, 0));
    for (int i = 0; i < 2; i++) cyc("drain_idle", 1, 0, 0, 0, 0, ev(3, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) cyc("iso", 1, 0, 0, 0, 0, ev(4, 0, 0, 0, 0));
    cyc("off_entry", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 1));
    cyc("off_hold", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));

    // Start held from OFF auto-wakes; a single strobe when ON is reached
    cyc("start_off", 1, 0, 0, 1, 0, ev(0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) cyc("start_held", 1, 0, 0, 1, 0, ev(1, 0, 0, 0, 0));
    cyc("start_strobe", 1, 0, 0, 1, 0, ev(2, 1, 1, 1, 0));
    cyc("start_done", 1, 0, 0, 0, 0, ev(2, 1, 0, 0, 0));

    // Sleep and start together; busy high 3 cycles, then a busy glitch
    cyc("sleep_start", 1, 0, 1, 1, 0, ev(2, 1, 1, 0, 0));
    cyc("drain_busy1", 1, 0, 0, 0, 1, ev(3, 0, 0, 0, 0));
    cyc("drain_busy2", 1, 0, 0, 1, 1, ev(3, 0, 0, 0, 0));
    cyc("drain_busy3", 1, 0, 0, 0, 1, ev(3, 0, 0, 0, 0));
    cyc("drain_low1", 1, 0, 0, 0, 0, ev(3, 0, 0, 0, 0));
    cyc("drain_glitch", 1, 0, 0, 0, 1, ev(3, 0, 0, 0, 0));
    cyc("drain_low1b", 1, 0, 0, 0, 0, ev(3, 0, 0, 0, 0));
    cyc("drain_low2", 1, 0, 0, 0, 0, ev(3, 0, 0, 0, 0));
    cyc("iso_a", 1, 0, 0, 0, 0, ev(4, 0, 0, 0, 0));
    // Wake arriving in ISO completes power-down, then restarts
    cyc("iso_wake", 1, 1, 0, 0, 0, ev(4, 0, 0, 0, 0));
    cyc("off_wake", 1, 1, 0, 0, 0, ev(0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) cyc("rewake_up", 1, 0, 0, 0, 0, ev(1, 0, 0, 0, 0));
    cyc("on_again", 1, 0, 0, 0, 0, ev(2, 1, 0, 1, 0));

`ifdef ALU_PWR_AUTO_OFF_EN
    for (int i = 0; i < 7; i++) cyc("idle_on", 1, 0, 0, 0, 0, ev(2, 1, 0, 0, 0));
    cyc("auto_off", 1, 0, 0, 0, 0, ev(3, 0, 0, 0, 0));
    cyc("rst_drain", 0, 0, 0, 0, 0, ev(3, 0, 0, 0, 0));
`else
    for (int i = 0; i < 20; i++) cyc("stay_on", 1, 0, 0, 0, 0, ev(2, 1, 0, 0, 0));
    cyc("rst_on", 0, 0, 0, 0, 0, ev(2, 1, 0, 0, 0));
`endif
    cyc("rst_off", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));

    // Reset during PWR_UP returns straight to OFF
    cyc("wake_rst", 1, 1, 0, 0, 0, ev(0, 0, 0, 0, 0));
    cyc("up_a", 1, 0, 0, 0, 0, ev(1, 0, 0, 0, 0));
    cyc("up_b", 1, 0, 0, 0, 0, ev(1, 0, 0, 0, 0));
    cyc("up_rst", 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0));
    cyc("after_rst", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));
    cyc("after_rst2", 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
